fetch_sequencer: RTL and testbench

Instruction-fetch sequencer for the pipelined datapath: owns the program counter, issues one word-address read at a time to instruction memory, and presents {PC, PC+1, instruction} to decode through a valid/ready handshake. It is the consumer of the PC+1 incrementer path, closing the loop from incrementer output back to the PC register. Branch/jump redirects from execute override sequential flow and squash any in-flight fetch.

---
 rtl/fetch_sequencer_pkg.sv | 15 +
 rtl/fetch_sequencer_incr.sv | 11 +
 rtl/fetch_sequencer.sv | 154 +++++++++++++++
 tb/tb_fetch_sequencer.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/fetch_sequencer_pkg.sv
// Shared types and defaults for the instruction-fetch sequencer.
package fetch_sequencer_pkg;

  localparam int          ADDR_W_DEF   = 32;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
  localparam int          INSTR_W      = 32;

  typedef enum logic [1:0] {
    ISSUE = 2'd0,
    WAIT  = 2'd1,
    HOLD  = 2'd2,
    DROP  = 2'd3
  } fetchState_t;

endpackage

// File: rtl/fetch_sequencer_incr.sv
// PC+1 incrementer; the carry out of the top bit is dropped so the PC wraps.
module fetch_sequencer_incr #(
  parameter int W = 32
) (
  input  logic [W-1:0] a,
  output logic [W-1:0] y
);

  assign y = a + {{(W-1){1'b0}}, 1'b1};

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction-fetch sequencer: owns the PC, keeps one memory read in flight at most,
// and hands {pc, pc+1, instr} to decode over a valid/ready handshake.
module fetch_sequencer
  import fetch_sequencer_pkg::*;
#(
  parameter int                ADDR_W   = ADDR_W_DEF,
  parameter logic [ADDR_W-1:0] RESET_PC = RESET_PC_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               redirect_i,
  input  logic [ADDR_W-1:0]  redirect_pc_i,
  output logic               imem_req_o,
  output logic [ADDR_W-1:0]  imem_addr_o,
  input  logic               imem_gnt_i,
  input  logic               imem_rvalid_i,
  input  logic [INSTR_W-1:0] imem_rdata_i,
  output logic               if_valid_o,
  input  logic               if_ready_i,
  output logic [ADDR_W-1:0]  if_pc_o,
  output logic [ADDR_W-1:0]  if_npc_o,
  output logic [INSTR_W-1:0] if_instr_o
);

  fetchState_t        state;
  logic [ADDR_W-1:0]  pc;
  logic [ADDR_W-1:0]  pktPc;
  logic [ADDR_W-1:0]  pktNpc;
  logic               memReq;
  logic [ADDR_W-1:0]  memAddr;
  logic               outValid;
  logic [ADDR_W-1:0]  outPc;
  logic [ADDR_W-1:0]  outNpc;
  logic [INSTR_W-1:0] outInstr;
  logic               issued;

  fetch_sequencer_incr #(.W(ADDR_W)) u_incr (
    .a (pktPc),
    .y (pktNpc)
  );

  assign issued = memReq & imem_gnt_i;

  // Fetch FSM; the request and packet outputs are registered alongside the state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= ISSUE;
      pc       <= RESET_PC;
      pktPc    <= {ADDR_W{1'b0}};
      memReq   <= 1'b0;
      memAddr  <= {ADDR_W{1'b0}};
      outValid <= 1'b0;
      outPc    <= {ADDR_W{1'b0}};
      outNpc   <= {ADDR_W{1'b0}};
      outInstr <= {INSTR_W{1'b0}};
    end else begin
      case (state)
        ISSUE: begin
          if (redirect_i) begin
            pc      <= redirect_pc_i;
            memAddr <= redirect_pc_i;
            if (issued) begin
              state  <= DROP;
              memReq <= 1'b0;
            end else begin
              state  <= ISSUE;
              memReq <= 1'b1;
            end
          end else if (issued) begin
            pktPc  <= memAddr;
            memReq <= 1'b0;
            state  <= WAIT;
          end else begin
            memReq  <= 1'b1;
            memAddr <= pc;
            state   <= ISSUE;
          end
        end
        WAIT: begin
          if (redirect_i) begin
            pc       <= redirect_pc_i;
            memAddr  <= redirect_pc_i;
            outValid <= 1'b0;
            // A response in the redirect cycle is simply discarded.
            if (imem_rvalid_i) begin
              state  <= ISSUE;
              memReq <= 1'b1;
            end else begin
              state  <= DROP;
              memReq <= 1'b0;
            end
          end else if (imem_rvalid_i) begin
            outValid <= 1'b1;
            outPc    <= pktPc;
            outNpc   <= pktNpc;
            outInstr <= imem_rdata_i;
            pc       <= pktNpc;
            memReq   <= 1'b0;
            state    <= HOLD;
          end else begin
            memReq <= 1'b0;
            state  <= WAIT;
          end
        end
        HOLD: begin
          if (redirect_i) begin
            pc       <= redirect_pc_i;
            memAddr  <= redirect_pc_i;
            outValid <= 1'b0;
            memReq   <= 1'b1;
            state    <= ISSUE;
          end else if (outValid && if_ready_i) begin
            outValid <= 1'b0;
            memAddr  <= pc;
            memReq   <= 1'b1;
            state    <= ISSUE;
          end else begin
            memReq <= 1'b0;
            state  <= HOLD;
          end
        end
        DROP: begin
          if (redirect_i) begin
            pc <= redirect_pc_i;
          end else begin
            pc <= pc;
          end
          // Orphaned response arrives: free the single outstanding slot.
          if (imem_rvalid_i) begin
            memAddr <= redirect_i ? redirect_pc_i : pc;
            memReq  <= 1'b1;
            state   <= ISSUE;
          end else begin
            memReq <= 1'b0;
            state  <= DROP;
          end
        end
        default: begin
          memReq   <= 1'b0;
          outValid <= 1'b0;
          state    <= ISSUE;
        end
      endcase
    end
  end

  assign imem_req_o  = memReq;
  assign imem_addr_o = memAddr;
  assign if_valid_o  = outValid;
  assign if_pc_o     = outPc;
  assign if_npc_o    = outNpc;
  assign if_instr_o  = outInstr;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed self-checking bench for fetch_sequencer with a small zero-wait memory responder.
module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i;
  logic        imem_rvalid_i;
  logic [31:0] imem_rdata_i;
  logic        if_valid_o;
  logic        if_ready_i;
  logic [31:0] if_pc_o;
  logic [31:0] if_npc_o;
  logic [31:0] if_instr_o;

  int   total = 0;
  int   bad = 0;
  int   cycleCnt = 0;
  logic autoMem = 1'b0;
  int   lastCyc;

  fetch_sequencer dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .imem_req_o    (imem_req_o),
    .imem_addr_o   (imem_addr_o),
    .imem_gnt_i    (imem_gnt_i),
    .imem_rvalid_i (imem_rvalid_i),
    .imem_rdata_i  (imem_rdata_i),
    .if_valid_o    (if_valid_o),
    .if_ready_i    (if_ready_i),
    .if_pc_o       (if_pc_o),
    .if_npc_o      (if_npc_o),
    .if_instr_o    (if_instr_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One clock; in auto mode memory grants always and answers next cycle with addr*16.
  task automatic tick();
    logic        iss;
    logic [31:0] a;
    iss = imem_req_o & imem_gnt_i;
    a   = imem_addr_o;
    @(posedge clk);
    #1;
    cycleCnt++;
    if (autoMem) begin
      imem_gnt_i    = 1'b1;
      imem_rvalid_i = iss;
      imem_rdata_i  = a << 4;
    end
  endtask

  task automatic waitValid();
    int n;
    n = 0;
    while (!if_valid_o && n < 20) begin
      tick();
      n++;
    end
    chk("wait_valid", {63'd0, if_valid_o}, 64'd1);
  endtask

  task automatic chkPkt(input string tag, input logic [31:0] p, input logic [31:0] np,
                        input logic [31:0] ins);
    chk({tag, "_pc"}, {32'd0, if_pc_o}, {32'd0, p});
    chk({tag, "_npc"}, {32'd0, if_npc_o}, {32'd0, np});
    chk({tag, "_instr"}, {32'd0, if_instr_o}, {32'd0, ins});
  endtask

  initial begin
    rst_n = 1'b0;
    redirect_i = 1'b0;
    redirect_pc_i = 32'd0;
    imem_gnt_i = 1'b0;
    imem_rvalid_i = 1'b0;
    imem_rdata_i = 32'd0;
    if_ready_i = 1'b1;

    // Reset held for three cycles
    repeat (3) tick();
    chk("rst_valid", {63'd0, if_valid_o}, 64'd0);
    chk("rst_req", {63'd0, imem_req_o}, 64'd0);
    chk("rst_pc", {32'd0, if_pc_o}, 64'd0);
    chk("rst_npc", {32'd0, if_npc_o}, 64'd0);
    chk("rst_instr", {32'd0, if_instr_o}, 64'd0);

    rst_n = 1'b1;
    tick();
    chk("first_req", {63'd0, imem_req_o}, 64'd1);
    chk("first_addr", {32'd0, imem_addr_o}, 64'd0);

    // Zero-wait memory stream, one packet per three cycles
    autoMem = 1'b1;
    imem_gnt_i = 1'b1;
    waitValid();
    chkPkt("p0", 32'd0, 32'd1, 32'd0);
    lastCyc = cycleCnt;
    tick();
    waitValid();
    chkPkt("p1", 32'd1, 32'd2, 32'd16);
    chk("p1_gap", 64'(cycleCnt - lastCyc), 64'd3);
    lastCyc = cycleCnt;
    tick();
    waitValid();
    chkPkt("p2", 32'd2, 32'd3, 32'd32);
    chk("p2_gap", 64'(cycleCnt - lastCyc), 64'd3);

    // Decode stalls on pc=3 for five cycles
    tick();
    if_ready_i = 1'b0;
    waitValid();
    chkPkt("p3", 32'd3, 32'd4, 32'd48);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("hold_valid", {63'd0, if_valid_o}, 64'd1);
      chkPkt("hold", 32'd3, 32'd4, 32'd48);
      chk("hold_noreq", {63'd0, imem_req_o}, 64'd0);
    end
    if_ready_i = 1'b1;
    tick();
    chk("after_hold_valid", {63'd0, if_valid_o}, 64'd0);
    chk("after_hold_req", {63'd0, imem_req_o}, 64'd1);
    chk("after_hold_addr", {32'd0, imem_addr_o}, 64'd4);

    // Redirect while waiting; late response 0xDEAD must be dropped
    autoMem = 1'b0;
    tick();
    imem_gnt_i = 1'b0;
    redirect_i = 1'b1;
    redirect_pc_i = 32'd64;
    tick();
    redirect_i = 1'b0;
    chk("drop_req", {63'd0, imem_req_o}, 64'd0);
    tick();
    chk("drop_valid", {63'd0, if_valid_o}, 64'd0);
    imem_rvalid_i = 1'b1;
    imem_rdata_i = 32'h0000_DEAD;
    tick();
    imem_rvalid_i = 1'b0;
    chk("drop_out_valid", {63'd0, if_valid_o}, 64'd0);
    chk("redir_req", {63'd0, imem_req_o}, 64'd1);
    chk("redir_addr", {32'd0, imem_addr_o}, 64'd64);
    imem_gnt_i = 1'b1;
    autoMem = 1'b1;
    waitValid();
    chkPkt("p64", 32'd64, 32'd65, 32'd1024);

    // Redirect to the top of the address space; npc wraps to 0
    redirect_i = 1'b1;
    redirect_pc_i = 32'hFFFF_FFFF;
    tick();
    redirect_i = 1'b0;
    chk("wrap_valid_clr", {63'd0, if_valid_o}, 64'd0);
    chk("wrap_req", {63'd0, imem_req_o}, 64'd1);
    chk("wrap_addr", {32'd0, imem_addr_o}, 64'hFFFF_FFFF);
    waitValid();
    chkPkt("pwrap", 32'hFFFF_FFFF, 32'd0, 32'hFFFF_FFF0);
    tick();
    chk("wrap_next_req", {63'd0, imem_req_o}, 64'd1);
    chk("wrap_next_addr", {32'd0, imem_addr_o}, 64'd0);

    // Reset while a read is outstanding; stale response after release ignored
    autoMem = 1'b0;
    tick();
    imem_gnt_i = 1'b0;
    rst_n = 1'b0;
    tick();
    chk("rst2_valid", {63'd0, if_valid_o}, 64'd0);
    chk("rst2_req", {63'd0, imem_req_o}, 64'd0);
    chk("rst2_pc", {32'd0, if_pc_o}, 64'd0);
    rst_n = 1'b1;
    imem_rvalid_i = 1'b1;
    imem_rdata_i = 32'h0000_0BAD;
    tick();
    imem_rvalid_i = 1'b0;
    chk("stale_valid", {63'd0, if_valid_o}, 64'd0);
    chk("stale_req", {63'd0, imem_req_o}, 64'd1);
    chk("stale_addr", {32'd0, imem_addr_o}, 64'd0);
    imem_gnt_i = 1'b1;
    autoMem = 1'b1;
    waitValid();
    chkPkt("prst", 32'd0, 32'd1, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
